// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDirect = 2'd1,
        StScan   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers cast the result down to their own width.
    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT_W = 2 ** MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/decoder_scan_dwell_timer.sv
// Dwell timer: counts 0..dwell while running and ticks on the last count of each line.
module dwell_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,  // first cycle of a scan: clear count, sample dwell
    input  logic               run,    // scanning; count advances, tick may fire
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    assign tick = run && (cnt_q == dwell_q);

    // Next count: clears unless running mid-line; dwell re-sampled on start and on every tick.
    always_comb begin
        cnt_d   = '0;
        dwell_d = dwell_q;
        if (start) begin
            dwell_d = dwell;
        end else if (run) begin
            if (tick) begin
                dwell_d = dwell;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count and sampled-dwell registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with direct-load and timed scan modes.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter  int unsigned SEL_W   = 3,  // at most MAX_SEL_W
    parameter  int unsigned DWELL_W = 8,
    localparam int unsigned OUT_W   = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   dec_out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    function automatic logic [OUT_W-1:0] line_of(input logic [SEL_W-1:0] s);
        return OUT_W'(onehot(MAX_SEL_W'(s)));
    endfunction

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   dec_out_q, dec_out_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic               wrap_q, wrap_d;
    logic [SEL_W-1:0]   cur_sel_inc;
    logic               timer_start, timer_run, timer_tick;

    // Held low during reset so no handshake can complete while the block is in reset.
    assign load_ready  = rst_n && enable && (mode == MODE_DIRECT);
    assign cur_sel_inc = cur_sel_q + 1'b1;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (timer_start),
        .run   (timer_run),
        .dwell (dwell),
        .tick  (timer_tick)
    );

    // Next state and output registers; enable low overrides everything, mode change beats advance.
    always_comb begin
        state_d     = state_q;
        dec_out_d   = dec_out_q;
        cur_sel_d   = cur_sel_q;
        wrap_d      = 1'b0;
        timer_start = 1'b0;
        timer_run   = 1'b0;
        if (!enable) begin
            state_d   = StIdle;
            dec_out_d = '0;
        end else begin
            case (mode)
                MODE_DIRECT: begin
                    state_d = StDirect;
                    // load_ready is high here, so an offered load is always taken.
                    if (load_valid) begin
                        cur_sel_d = sel_in;
                        dec_out_d = line_of(sel_in);
                    end else if (state_q == StIdle) begin
                        dec_out_d = line_of(cur_sel_q);
                    end
                end
                MODE_SCAN: begin
                    state_d = StScan;
                    if (state_q != StScan) begin
                        timer_start = 1'b1;
                        dec_out_d   = line_of(cur_sel_q);
                    end else begin
                        timer_run = 1'b1;
                        if (timer_tick) begin
                            cur_sel_d = cur_sel_inc;
                            dec_out_d = line_of(cur_sel_inc);
                            wrap_d    = &cur_sel_q;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dec_out_q <= '0;
            cur_sel_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_out_q <= dec_out_d;
            cur_sel_q <= cur_sel_d;
            wrap_q    <= wrap_d;
        end
    end

    assign dec_out = dec_out_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule
